freq_div_multi: RTL

//  Multi-channel frequency divider. The divide factor of each channel is programmable at run time.
//  - Successor to the fixed-FACTOR divider: NCH independent channels, each with its own counter.
//  - Updates are shadowed and take effect only at a period boundary, so no glitch or runt pulse.
//  - Sits in the clocking/timebase area and drives low-rate strobes and slow clocks to peripherals.

---
 rtl/freq_div_pkg.sv | 14 +
 rtl/freq_div_ch.sv | 74 +++++++
 rtl/freq_div_multi.sv | 48 ++++
 3 files changed

// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the multi-channel frequency divider.
package freq_div_pkg;

   localparam int unsigned MIN_DIV = 2;

   function automatic int unsigned clamp_div(input int unsigned d);
      return (d < MIN_DIV) ? MIN_DIV : d;
   endfunction

   function automatic int unsigned half_div(input int unsigned n);
      return n >> 1;
   endfunction

endpackage

// File: rtl/freq_div_ch.sv
// One divider channel: counter, active/shadow factor, pending flag, output flops.
// Optional ODD_HALF_DUTY_EN adds a negedge flop to stretch odd factors to 50% duty.
module freq_div_ch
   import freq_div_pkg::*;
#(
   parameter int W           = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic         clk_in,
   input  logic         rstn,
   input  logic         en,
   input  logic         wr,
   input  logic [W-1:0] wr_div,
   output logic         freq_out,
   output logic         period_tick,
   output logic         pending,
   output logic         err
);

   logic [W-1:0] cnt, n_act, n_shd, half, div_c;
   logic         p, wrap, apply;

   assign div_c = W'(clamp_div(32'(wr_div)));
   assign half  = W'(half_div(32'(n_act)));
   assign wrap  = (cnt == n_act - W'(1));
   // Shadow only moves to active at a period boundary or when the channel is stopped.
   assign apply = pending && (!en || wrap);

   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         cnt         <= '0;
         n_act       <= W'(DEFAULT_DIV);
         n_shd       <= W'(DEFAULT_DIV);
         pending     <= 1'b0;
         p           <= 1'b0;
         period_tick <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (wr)    n_shd <= div_c;
         if (apply) n_act <= n_shd;
         pending <= wr | (pending & ~apply);
         err     <= err | (wr & (32'(wr_div) < MIN_DIV));
         if (!en) begin
            cnt         <= '0;
            p           <= 1'b0;
            period_tick <= 1'b0;
         end else begin
            p           <= (cnt < half);
            period_tick <= (cnt == '0);
            cnt         <= wrap ? '0 : cnt + W'(1);
         end
      end
   end

`ifdef ODD_HALF_DUTY_EN
   logic n, run;

   always_ff @(negedge clk_in or negedge rstn) begin
      if (!rstn) n <= 1'b0;
      else       n <= p;
   end

   // run kills the trailing half-cycle as soon as the channel is disabled.
   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) run <= 1'b0;
      else       run <= en;
   end

   assign freq_out = p | (n & n_act[0] & run);
`else
   assign freq_out = p;
`endif

endmodule

// File: rtl/freq_div_multi.sv
// NCH-channel programmable frequency divider with shadowed, boundary-applied factors.
// Define ODD_HALF_DUTY_EN for exact 50% duty on odd factors.
module freq_div_multi
   import freq_div_pkg::*;
#(
   parameter int NCH         = 2,
   parameter int W           = 8,
   parameter int DEFAULT_DIV = 4,
   localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk_in,
   input  logic           rstn,
   input  logic [NCH-1:0] en,
   input  logic           cfg_wr,
   input  logic [CW-1:0]  cfg_ch,
   input  logic [W-1:0]   cfg_div,
   output logic [NCH-1:0] freq_out,
   output logic [NCH-1:0] period_tick,
   output logic [NCH-1:0] pending,
   output logic           cfg_err
);

   logic [NCH-1:0] ch_err;

   // Out-of-range cfg_ch matches no channel, so the write is dropped.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic sel;
      assign sel = cfg_wr && (cfg_ch == CW'(i));

      freq_div_ch #(
         .W           (W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in      (clk_in),
         .rstn        (rstn),
         .en          (en[i]),
         .wr          (sel),
         .wr_div      (cfg_div),
         .freq_out    (freq_out[i]),
         .period_tick (period_tick[i]),
         .pending     (pending[i]),
         .err         (ch_err[i])
      );
   end

   assign cfg_err = |ch_err;

endmodule
